// File: rtl/dkong_rom_arb.sv
// dkong_rom_arb: shares one ROM port among the main CPU, the sound CPU and the wave sampler.
// Priority is CPU > SND > WAV, but a wave request that has waited MAX_WAIT cycles wins outright.
module dkong_rom_arb #(
    parameter int MAX_WAIT = 64,
    parameter int TIMEOUT  = 255
) (
    input  logic        I_CLK,
    input  logic        I_RSTn,
    input  logic        I_CPU_STB,
    input  logic [18:0] I_CPU_AB,
    output logic [7:0]  O_CPU_DO,
    output logic        O_CPU_RDY,
    input  logic        I_SND_STB,
    input  logic [18:0] I_SND_AB,
    output logic [7:0]  O_SND_DO,
    output logic        O_SND_RDY,
    input  logic        I_WAV_STB,
    input  logic [18:0] I_WAV_AB,
    output logic [7:0]  O_WAV_DO,
    output logic        O_WAV_OVR,
    output logic        O_MEM_REQ,
    output logic [18:0] O_MEM_AB,
    input  logic        I_MEM_ACK,
    input  logic [7:0]  I_MEM_DO,
    output logic        O_ERR
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] L_WAIT = WW'(MAX_WAIT);
    localparam logic [TW-1:0] L_TLIM = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        r_st, w_st_nx;
    logic [2:0]    w_stb, w_gsel, w_wsel, w_fly, w_fin3, r_pend, r_que;
    logic [18:0]   w_ab [3];
    logic [18:0]   r_ab [3];
    logic [18:0]   w_win_ab, r_mab;
    logic [1:0]    w_win, r_gnt;
    logic          w_gnt, w_fin, w_tout;
    logic          r_req, r_cpu_rdy, r_snd_rdy, r_ovr, r_err;
    logic [7:0]    w_rdata, r_cpu_do, r_snd_do, r_wav_do;
    logic [WW-1:0] r_wwait;
    logic [TW-1:0] r_tmo;

    assign w_stb    = {I_WAV_STB, I_SND_STB, I_CPU_STB};
    assign w_ab[0]  = I_CPU_AB;
    assign w_ab[1]  = I_SND_AB;
    assign w_ab[2]  = I_WAV_AB;
    assign w_win    = (r_pend[2] && r_wwait >= L_WAIT) ? 2'd2 :
                      r_pend[0] ? 2'd0 : r_pend[1] ? 2'd1 : 2'd2;
    assign w_win_ab = (w_win == 2'd0) ? r_ab[0] : (w_win == 2'd1) ? r_ab[1] : r_ab[2];
    assign w_gsel   = 3'b001 << r_gnt;
    assign w_wsel   = 3'b001 << w_win;
    // A requester is in flight while its access is in BUSY, including the grant edge itself.
    assign w_fly    = ({3{r_st == BUSY}} & w_gsel) | ({3{w_gnt}} & w_wsel);
    assign w_fin3   = {3{w_fin}} & w_gsel;
    assign w_rdata  = !w_tout ? I_MEM_DO : (r_gnt == 2'd2) ? 8'h80 : 8'hFF;

    assign O_CPU_DO  = r_cpu_do;
    assign O_CPU_RDY = r_cpu_rdy;
    assign O_SND_DO  = r_snd_do;
    assign O_SND_RDY = r_snd_rdy;
    assign O_WAV_DO  = r_wav_do;
    assign O_WAV_OVR = r_ovr;
    assign O_MEM_REQ = r_req;
    assign O_MEM_AB  = r_mab;
    assign O_ERR     = r_err;

    always_comb begin
        w_st_nx = r_st;
        w_gnt   = 1'b0;
        w_fin   = 1'b0;
        w_tout  = 1'b0;
        case (r_st)
            IDLE: begin
                w_gnt   = |r_pend;
                w_st_nx = w_gnt ? BUSY : IDLE;
            end
            BUSY: begin
                w_tout  = !I_MEM_ACK && r_tmo == L_TLIM;
                w_fin   = I_MEM_ACK || w_tout;
                w_st_nx = w_fin ? DONE : BUSY;
            end
            default: w_st_nx = IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            r_st      <= IDLE;
            r_pend    <= '0;
            r_que     <= '0;
            r_gnt     <= '0;
            r_mab     <= '0;
            r_req     <= 1'b0;
            r_cpu_rdy <= 1'b0;
            r_snd_rdy <= 1'b0;
            r_cpu_do  <= '0;
            r_snd_do  <= '0;
            r_wav_do  <= 8'h80;
            r_ovr     <= 1'b0;
            r_err     <= 1'b0;
            r_wwait   <= '0;
            r_tmo     <= '0;
            for (int i = 0; i < 3; i++) r_ab[i] <= '0;
        end else begin
            r_st <= w_st_nx;
            // A strobe during its own access queues behind it; one on the completion edge survives it.
            for (int i = 0; i < 3; i++) begin
                if (w_stb[i]) r_ab[i] <= w_ab[i];
                if (w_fin3[i]) begin
                    r_pend[i] <= w_stb[i] | r_que[i];
                    r_que[i]  <= 1'b0;
                end else if (w_stb[i]) begin
                    r_pend[i] <= 1'b1;
                    if (w_fly[i]) r_que[i] <= 1'b1;
                end
            end
            if (w_stb[2] && r_pend[2] && !w_fly[2]) r_ovr <= 1'b1;
            if (w_gnt && w_win == 2'd2) r_wwait <= '0;
            else if (r_pend[2] && !w_fly[2] && r_wwait != L_WAIT) r_wwait <= r_wwait + 1'b1;
            if (w_gnt) begin
                r_gnt <= w_win;
                r_mab <= w_win_ab;
                r_req <= 1'b1;
                r_tmo <= '0;
            end else if (r_st == BUSY) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_fin) r_req <= 1'b0;
            if (w_tout) r_err <= 1'b1;
            r_cpu_rdy <= w_fin3[0];
            r_snd_rdy <= w_fin3[1];
            if (w_fin3[0]) r_cpu_do <= w_rdata;
            if (w_fin3[1]) r_snd_do <= w_rdata;
            if (w_fin3[2]) r_wav_do <= w_rdata;
        end
    end
endmodule

// File: doc/dkong_rom_arb.md
DKONG_ROM_ARB -- requirements
Module: dkong_rom_arb

Interface
REQ-001 Parameter MAX_WAIT, default 64: cycles a pending wave request may wait before it is promoted to top priority.
REQ-002 Parameter TIMEOUT, default 255: cycles without I_MEM_ACK before an in-flight access is aborted.
REQ-003 I_CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 I_RSTn  input  1  asynchronous, active-low reset.
REQ-005 I_CPU_STB  input  1  one-cycle pulse: main CPU requests the byte at I_CPU_AB.
REQ-006 I_CPU_AB  input  19  main CPU ROM byte address, sampled on I_CPU_STB.
REQ-007 O_CPU_DO / O_CPU_RDY  output  8 / 1  main CPU read data, held until the next CPU completion / one-cycle completion pulse.
REQ-008 I_SND_STB, I_SND_AB[18:0], O_SND_DO[7:0], O_SND_RDY  same roles and widths as REQ-005..007, for the sound CPU.
REQ-009 I_WAV_STB  input  1  one-cycle pulse at each wave sample tick.
REQ-010 I_WAV_AB  input  19  wave sample address from the wave sound generator, sampled on I_WAV_STB.
REQ-011 O_WAV_DO  output  8  current unsigned wave sample, held between fetches.
REQ-012 O_WAV_OVR  output  1  sticky flag: a wave sample was dropped.
REQ-013 O_MEM_REQ  output  1  level request to the shared ROM.
REQ-014 O_MEM_AB  output  19  ROM address, stable while O_MEM_REQ=1.
REQ-015 I_MEM_ACK  input  1  one-cycle pulse; I_MEM_DO is valid in the same cycle.
REQ-016 I_MEM_DO  input  8  ROM read data.
REQ-017 O_ERR  output  1  sticky flag: at least one access timed out.

Function
REQ-018 Each requester SHALL have a pending flag and a 19-bit address latch; a strobe SHALL set the flag and load the latch on the same edge.
REQ-019 A strobe while the same requester is pending but not granted SHALL overwrite the latch (latest address wins); for the wave requester this SHALL also set O_WAV_OVR.
REQ-020 A strobe while the same requester is in flight SHALL queue one new pending request, served after the current access completes.
REQ-021 A strobe in the same cycle as that requester's completion SHALL leave its pending flag set with the new address.
REQ-022 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-023 IDLE with any pending flag set: grant the winner, register O_MEM_AB from its latch, set O_MEM_REQ=1, go to BUSY.
REQ-024 Winner priority SHALL be: wave if its wait counter is at least MAX_WAIT; otherwise CPU, then SND, then WAV.
REQ-025 The wave wait counter SHALL count cycles while the wave request is pending and not granted, saturate at MAX_WAIT, and clear on wave grant.
REQ-026 BUSY with I_MEM_ACK=1: capture I_MEM_DO into the winner's output register, clear O_MEM_REQ and the winner's pending flag, go to DONE.
REQ-027 DONE: pulse the winner's RDY for exactly one cycle (the wave path has no RDY pulse), then return to IDLE.
REQ-028 The minimum latency is 3 cycles from a strobe on an idle arbiter to RDY, plus the ROM ack delay.
REQ-029 The timeout counter SHALL clear on grant and count in BUSY; on reaching TIMEOUT without an ack the block SHALL:
  - deassert O_MEM_REQ;
  - load the winner's output with 8'hFF (wave: 8'h80);
  - set O_ERR;
  - go to DONE.
REQ-030 I_MEM_ACK outside BUSY SHALL be ignored.
REQ-031 O_MEM_AB SHALL change only on the IDLE->BUSY edge.

Reset
REQ-032 While I_RSTn=0:
  - all pending flags, latches, counters, O_MEM_REQ, O_MEM_AB, O_*_RDY, O_CPU_DO, O_SND_DO, O_WAV_OVR and O_ERR SHALL be 0;
  - O_WAV_DO SHALL be 8'h80;
  - the FSM SHALL be in IDLE.
REQ-033 Reset asserted mid-access SHALL drop O_MEM_REQ immediately and discard all pending requests; an ack arriving after reset release SHALL be ignored.

Verification
REQ-034 CPU strobe, AB=19'h01234, ack with DO=8'h5A 2 cycles after REQ -> O_MEM_AB=19'h01234, O_CPU_DO=8'h5A, one O_CPU_RDY pulse, no other RDY pulse.
REQ-035 CPU, SND and WAV strobes in the same cycle -> grant order CPU, SND, WAV; three MEM_REQ phases, each address matching its latch.
REQ-036 WAV pending while the CPU strobes on every completion, MAX_WAIT=64 -> WAV is granted at the first IDLE after its wait counter reaches 64.
REQ-037 Two WAV strobes before the wave grant (AB 19'h10000, then 19'h10001) -> only 19'h10001 is fetched and O_WAV_OVR=1.
REQ-038 SND access with no ack for 255 cycles -> O_MEM_REQ falls, O_SND_DO=8'hFF, O_SND_RDY pulses, O_ERR=1; a following CPU access completes normally.
REQ-039 Reset pulsed during BUSY, then a late ack -> all outputs at reset values, O_WAV_DO=8'h80, and the ack has no effect.
